// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the word-addressed instruction memory,
// steps the PC and loads the IF/ID register. A one-entry skid buffer absorbs
// the in-flight read when decode stalls, a redirect from execute flushes the
// stage, and a HALT_WORD parks the stage until the next redirect or reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, no fetch; waits for i_start
// S_FETCH   | issuing one read per unstalled cycle, filling IF/ID
// S_HALTED  | halt word seen; no fetch until a redirect
module fetch_unit #(
   parameter int                  ADDR_W    = 10,
   parameter int                  INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]  HALT_WORD = {INSTR_W{1'b1}}
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   output logic                o_imem_rd_en,
   output logic [ADDR_W-1:0]   o_imem_addr,
   input  logic [INSTR_W-1:0]  i_imem_rdata,
   input  logic                i_stall,
   input  logic                i_redirect,
   input  logic [ADDR_W-1:0]   i_redirect_pc,
   output logic                o_ifid_valid,
   output logic [INSTR_W-1:0]  o_ifid_instr,
   output logic [ADDR_W-1:0]   o_ifid_pc,
   output logic [1:0]          o_ifid_type,
   output logic [4:0]          o_ifid_func,
   output logic                o_halted
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_req_valid;
   logic [ADDR_W-1:0]  r_req_pc;
   logic               r_skid_valid;
   logic [INSTR_W-1:0] r_skid;
   logic [ADDR_W-1:0]  r_skid_pc;
   logic               r_ifid_valid;
   logic [INSTR_W-1:0] r_ifid_instr;
   logic [ADDR_W-1:0]  r_ifid_pc;
   logic               r_halted;

   logic               w_advance;
   logic               w_ret_valid;
   logic [INSTR_W-1:0] w_ret_word;
   logic [ADDR_W-1:0]  w_ret_pc;
   logic               w_halt;

   // An unstalled, unredirected FETCH cycle both issues a read and retires
   // whatever is returning; the skid entry is older than the memory return.
   always_comb begin
      w_advance   = (r_state == S_FETCH) & ~i_stall & ~i_redirect;
      w_ret_valid = r_skid_valid | r_req_valid;
      w_ret_word  = r_skid_valid ? r_skid    : i_imem_rdata;
      w_ret_pc    = r_skid_valid ? r_skid_pc : r_req_pc;
      w_halt      = w_advance & w_ret_valid & (w_ret_word == HALT_WORD);
   end

   assign o_imem_rd_en = w_advance & ~i_rst;
   assign o_imem_addr  = r_pc;
   assign o_ifid_valid = r_ifid_valid;
   assign o_ifid_instr = r_ifid_instr;
   assign o_ifid_pc    = r_ifid_pc;
   assign o_ifid_type  = r_ifid_instr[INSTR_W-1:INSTR_W-2];
   assign o_ifid_func  = r_ifid_instr[INSTR_W-3:INSTR_W-7];
   assign o_halted     = r_halted;

   // Sequencer, request tracking, skid buffer and IF/ID register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_pc         <= '0;
         r_req_valid  <= 1'b0;
         r_req_pc     <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
         r_skid_pc    <= '0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
         r_halted     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (i_redirect) begin
                  r_pc         <= i_redirect_pc;
                  r_req_valid  <= 1'b0;
                  r_skid_valid <= 1'b0;
                  r_ifid_valid <= 1'b0;
               end else if (i_stall) begin
                  // Only one read can be in flight, so the skid never overflows.
                  r_req_valid <= 1'b0;
                  if (r_req_valid) begin
                     r_skid       <= i_imem_rdata;
                     r_skid_pc    <= r_req_pc;
                     r_skid_valid <= 1'b1;
                  end
               end else if (w_halt) begin
                  // The read issued this cycle is dropped and pc is not advanced.
                  r_ifid_valid <= 1'b0;
                  r_req_valid  <= 1'b0;
                  r_skid_valid <= 1'b0;
                  r_halted     <= 1'b1;
                  r_state      <= S_HALTED;
               end else begin
                  r_req_pc     <= r_pc;
                  r_req_valid  <= 1'b1;
                  r_pc         <= r_pc + PC_ONE;
                  r_skid_valid <= 1'b0;
                  r_ifid_valid <= w_ret_valid;
                  if (w_ret_valid) begin
                     r_ifid_instr <= w_ret_word;
                     r_ifid_pc    <= w_ret_pc;
                  end
               end
            end
            S_HALTED: begin
               if (i_redirect) begin
                  r_pc         <= i_redirect_pc;
                  r_req_valid  <= 1'b0;
                  r_skid_valid <= 1'b0;
                  r_ifid_valid <= 1'b0;
                  r_halted     <= 1'b0;
                  r_state      <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a registered instruction memory model,
// a queue of expected (pc, instr) pairs pushed by each scenario and popped
// whenever IF/ID takes a new instruction, plus directed checks on control
// outputs around stalls, redirects, halts and reset.
module tb_fetch_unit;

   localparam int AW = 10;
   localparam int IW = 32;
   localparam logic [IW-1:0] HALT = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          imem_rd_en;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata = '0;
   logic          stall;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          ifid_valid;
   logic [IW-1:0] ifid_instr;
   logic [AW-1:0] ifid_pc;
   logic [1:0]    ifid_type;
   logic [4:0]    ifid_func;
   logic          halted;

   logic [IW-1:0]      mem [1024];
   logic [AW+IW-1:0]   sb_q [$];
   int                 n_chk = 0;
   int                 n_err = 0;
   logic               prev_stall = 1'b0;
   logic               prev_rst   = 1'b1;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .HALT_WORD(HALT)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .o_imem_rd_en  (imem_rd_en),
      .o_imem_addr   (imem_addr),
      .i_imem_rdata  (imem_rdata),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_ifid_valid  (ifid_valid),
      .o_ifid_instr  (ifid_instr),
      .o_ifid_pc     (ifid_pc),
      .o_ifid_type   (ifid_type),
      .o_ifid_func   (ifid_func),
      .o_halted      (halted)
   );

   // memory model: data valid the cycle after the read request
   always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

   always @(posedge clk) begin
      prev_stall <= stall;
      prev_rst   <= rst;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // A valid IF/ID after an edge with no stall and no reset is a fresh load.
   always @(negedge clk) begin
      if (!prev_rst && !prev_stall && ifid_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", {ifid_pc, ifid_instr}, 64'd0);
         end else begin
            logic [AW+IW-1:0] e;
            e = sb_q.pop_front();
            chk("sb_pc_instr", {ifid_pc, ifid_instr}, e);
            chk("sb_type_func", {ifid_type, ifid_func}, e[IW-1:IW-7]);
         end
      end
   end

   task automatic push_exp(input int pc);
      sb_q.push_back({pc[AW-1:0], mem[pc]});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ifid(input int pc, input string tag);
      int k = 0;
      while (!(ifid_valid && ifid_pc == pc[AW-1:0]) && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(ifid_valid && ifid_pc == pc[AW-1:0]), 64'd1);
   endtask

   task automatic wait_halt(input string tag);
      int k = 0;
      while (!halted && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(halted), 64'd1);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (sb_q.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic do_redirect(input int pc);
      redirect    = 1'b1;
      redirect_pc = pc[AW-1:0];
      tick(1);
      redirect    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] a;
         a = i[9:0];
         mem[i] = {a[1:0], a[6:2], 15'h1234, a};
      end
      mem[8]    = HALT;
      mem[8'h23] = HALT;
      mem[8'h42] = HALT;

      rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      tick(3);
      chk("rst_rd_en", 64'(imem_rd_en), 64'd0);
      rst = 1'b0;
      tick(1);
      chk("rst_state", {ifid_valid, ifid_pc, ifid_instr, halted, imem_addr, imem_rd_en},
          64'd0);

      // sequential fetch, then a 3-cycle stall after (1,B)
      for (int p = 0; p < 8; p++) push_exp(p);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_ifid(1, "seq_reach_1");
      stall = 1'b1;
      #1 chk("stall_rd_en", 64'(imem_rd_en), 64'd0);
      tick(1);
      chk("stall_hold1", {ifid_valid, ifid_pc, imem_rd_en}, {1'b1, 10'd1, 1'b0});
      tick(1);
      chk("stall_hold2", {ifid_valid, ifid_pc, imem_rd_en}, {1'b1, 10'd1, 1'b0});
      tick(1);
      stall = 1'b0;
      drain("seq_drain");
      wait_halt("seq_halt");

      // redirect out of halt, then a flushing redirect while 0x12 is in IF/ID
      push_exp('h10); push_exp('h11); push_exp('h12);
      push_exp('h20); push_exp('h21); push_exp('h22);
      do_redirect('h10);
      chk("unhalt", 64'(halted), 64'd0);
      wait_ifid('h12, "redir_reach");
      redirect = 1'b1; redirect_pc = 10'h20;
      tick(1);
      redirect = 1'b0;
      chk("flush_v0", 64'(ifid_valid), 64'd0);
      chk("flush_addr", 64'(imem_addr), 64'h20);
      tick(1);
      chk("flush_v1", 64'(ifid_valid), 64'd0);
      tick(1);
      chk("flush_target", {ifid_valid, ifid_pc}, {1'b1, 10'h20});
      drain("redir_drain");
      wait_halt("redir_halt");

      // redirect and stall together while the skid holds 0x32
      push_exp('h30); push_exp('h31); push_exp('h40); push_exp('h41);
      do_redirect('h30);
      wait_ifid('h31, "rs_reach");
      stall = 1'b1;
      tick(1);
      redirect = 1'b1; redirect_pc = 10'h40;
      tick(1);
      redirect = 1'b0; stall = 1'b0;
      chk("rs_flush", 64'(ifid_valid), 64'd0);
      drain("rs_drain");
      wait_halt("rs_halt");

      // PC wrap into a halt word
      mem[1023] = 32'h1ABC_0001;
      mem[0]    = 32'h8765_4321;
      mem[1]    = HALT;
      push_exp(1023); push_exp(0);
      do_redirect(1023);
      drain("wrap_drain");
      wait_halt("wrap_halt");
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("halted_idle", {halted, ifid_valid, imem_rd_en}, {1'b1, 1'b0, 1'b0});
      end
      push_exp(5); push_exp(6); push_exp(7);
      do_redirect(5);
      chk("wrap_unhalt", 64'(halted), 64'd0);
      drain("resume_drain");
      wait_halt("resume_halt");

      // reset while stalled with a skid entry held
      push_exp('h50); push_exp('h51);
      do_redirect('h50);
      wait_ifid('h51, "rst_reach");
      stall = 1'b1;
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("midrst_state", {ifid_valid, ifid_pc, ifid_instr, halted, imem_addr, imem_rd_en},
          64'd0);
      rst = 1'b0; stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("midrst_idle", {imem_rd_en, ifid_valid}, 2'b00);
      end
      push_exp(0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      drain("restart_drain");
      wait_halt("restart_halt");
      tick(3);
      chk("sb_final", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the instruction stream the control unit decodes. It drives the word-addressed instruction memory, steps the PC, and loads the IF/ID register with the instruction, its type/func fields and its PC. It absorbs stalls with a one-entry skid buffer, flushes on branch redirects from execute, and stops on a halt word.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width
INSTR_W, 32, instruction width; type = [INSTR_W-1:INSTR_W-2], func = [INSTR_W-3:INSTR_W-7]
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  leave IDLE and begin fetching at PC 0
imem_rd_en  out  1  read request this cycle
imem_addr  out  ADDR_W  read address; equals pc register
imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en=1
stall  in  1  hazard stall from decode; hold IF/ID
redirect  in  1  taken branch from execute (BranchB, or BranchI/BranchNI resolved)
redirect_pc  in  ADDR_W  branch target
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc  out  ADDR_W  PC of ifid_instr
ifid_type  out  2  ifid_instr type field (to control unit)
ifid_func  out  5  ifid_instr func field (to control unit)
halted  out  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (rst=1 at edge, wins over everything): state=IDLE, pc=0, req_valid=0, skid_valid=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, halted=0. imem_rd_en=0 during reset.
- States: IDLE, FETCH, HALTED.
- IDLE: imem_rd_en=0; start=1 -> FETCH next cycle. redirect is ignored.
- FETCH: imem_rd_en = ~stall & ~redirect. On an issuing edge: req_pc<=pc, req_valid<=1, and pc<=pc+1 (wraps mod 2^ADDR_W). A non-issuing edge sets req_valid<=0.
- Return path, FETCH with stall=0 and redirect=0:
  - If skid_valid=1: IF/ID loads {skid, skid_pc}, ifid_valid=1, skid_valid<=0.
  - Else if req_valid=1: IF/ID loads {imem_rdata, req_pc}, ifid_valid=1.
  - Else: ifid_valid<=0 (bubble).
- Stall (stall=1, redirect=0):
  - IF/ID, pc and ifid_valid hold.
  - If req_valid=1, imem_rdata and req_pc go into the skid buffer, skid_valid<=1.
  - At most one outstanding request, so the skid cannot overflow.
- Redirect (redirect=1, any state except IDLE, priority over stall):
  - pc<=redirect_pc; req_valid<=0; skid_valid<=0; ifid_valid<=0 (flush).
  - In HALTED: halted<=0, state->FETCH.
  - Timing: redirect in cycle n -> imem_addr=redirect_pc in cycle n+1 -> target in IF/ID with ifid_valid=1 after the edge ending cycle n+2.
- Halt: when the word about to load IF/ID (from skid or imem_rdata) equals HALT_WORD:
  - IF/ID is not loaded and ifid_valid<=0; req_valid<=0; pc holds; state->HALTED; halted<=1.
  - HALTED: imem_rd_en=0; exits only by rst or redirect.
- Steady throughput: 1 instruction per cycle; first instruction valid 2 edges after FETCH entry.
- ifid_type/ifid_func are combinational slices of ifid_instr.

Test Plan:
- Sequential fetch: mem[0..3]=A,B,C,D; start pulse -> ifid (pc,instr) = (0,A),(1,B),(2,C),(3,D) on consecutive cycles, ifid_valid=1 continuously.
- Stall with skid: stall=1 for 3 cycles after (1,B) loads -> IF/ID holds (1,B), imem_rd_en=0; on release (2,C) then (3,D) on consecutive cycles, nothing lost or duplicated.
- Redirect flush: redirect=1, redirect_pc=0x20 while (2,C) in IF/ID -> ifid_valid=0 for 2 cycles, then (0x20, mem[0x20]); the wrong-path word is never valid.
- Redirect+stall same cycle with skid_valid=1 -> redirect wins, skid dropped, fetch resumes at target.
- Halt and wrap: mem[2^ADDR_W-1]=X, mem[0]=Y, mem[1]=HALT_WORD, start at pc 2^ADDR_W-1 via redirect -> (1023,X),(0,Y), then halted=1, ifid_valid=0, imem_rd_en=0 thereafter; later redirect to 5 -> halted=0, (5,mem[5]).
- Reset mid-operation: rst=1 during a stall with skid_valid=1 -> next cycle all outputs at reset values, state IDLE, no fetch until start.
